// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - two-stage pipelined bitwise logic unit with stall/flush
// and a saturating count of retired results.
module logic_pipe #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_op,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [W-1:0]     out_result,
  output logic             out_zero,
  output logic             out_valid,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic [1:0]       s1_op;
  logic [W-1:0]     s1_res;

  always_comb begin
    s1_res = '0;
    case (s1_op)
      OP_AND:  s1_res = s1_a & s1_b;
      OP_OR:   s1_res = s1_a | s1_b;
      OP_XOR:  s1_res = s1_a ^ s1_b;
      default: s1_res = ~(s1_a | s1_b);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_valid  <= 1'b0;
      done_cnt   <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_a      <= in_a;
      s1_b      <= in_b;
      s1_op     <= in_op;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= s1_res;
        out_zero   <= (s1_res == '0);
      end
      // The result leaving S2 on this edge retires; a stalled one waits here.
      if (out_valid && done_cnt != CNT_MAX) begin
        done_cnt <= done_cnt + 1'b1;
      end
    end
  end

endmodule
